// File: rtl/bus_arbiter.sv
// bus_arbiter: N-master to 1-slave round-robin memory bus arbiter.
// Optional response timeout converts a hung slave into a bus fault.
module bus_arbiter #(
  parameter int N_PORTS = 2,
  parameter int TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [32*N_PORTS-1:0]  m_address_in,
  input  logic [N_PORTS-1:0]     m_read_in,
  input  logic [N_PORTS-1:0]     m_write_in,
  input  logic [4*N_PORTS-1:0]   m_write_mask_in,
  input  logic [32*N_PORTS-1:0]  m_write_value_in,
  output logic [31:0]            m_read_value_out,
  output logic [N_PORTS-1:0]     m_ready_out,
  output logic [N_PORTS-1:0]     m_fault_out,
  output logic [31:0]            s_address_out,
  output logic                   s_read_out,
  output logic                   s_write_out,
  output logic [3:0]             s_write_mask_out,
  output logic [31:0]            s_write_value_out,
  input  logic [31:0]            s_read_value_in,
  input  logic                   s_ready_in,
  input  logic                   s_fault_in
);

  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] LAST_RST = GW'(N_PORTS - 1);
  localparam logic [TW-1:0] T_LAST =
    (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [N_PORTS-1:0] req;
  logic [GW-1:0]   pick;
  logic            found;
  logic            done;

  assign req = m_read_in | m_write_in;
  assign m_read_value_out = s_read_value_in;

  // Round-robin pick: first requester after the last served port
  always_comb begin
    int idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = (int'(last_q) + k) % N_PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // State, grant, last-served and timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  // Next state and bus muxing; slave fields follow the granted master
  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_d            = last_q;
    timer_d           = timer_q;
    done              = 1'b0;
    s_address_out     = '0;
    s_read_out        = 1'b0;
    s_write_out       = 1'b0;
    s_write_mask_out  = '0;
    s_write_value_out = '0;
    m_ready_out       = '0;
    m_fault_out       = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = BUSY;
          timer_d = '0;
        end
      end
      BUSY: begin
        s_address_out     = m_address_in[32*grant_q +: 32];
        s_read_out        = m_read_in[grant_q];
        s_write_out       = m_write_in[grant_q];
        s_write_mask_out  = m_write_mask_in[4*grant_q +: 4];
        s_write_value_out = m_write_value_in[32*grant_q +: 32];
        if (s_fault_in) begin
          m_fault_out[grant_q] = 1'b1;
          done = 1'b1;
        end else if (s_ready_in) begin
          m_ready_out[grant_q] = 1'b1;
          done = 1'b1;
        end else if (!req[grant_q]) begin
          done = 1'b1;
        end else if (TIMEOUT > 0 && timer_q == T_LAST) begin
          m_fault_out[grant_q] = 1'b1;
          s_read_out  = 1'b0;
          s_write_out = 1'b0;
          done = 1'b1;
        end else if (TIMEOUT > 0) begin
          timer_d = timer_q + TW'(1);
        end
        if (done) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      s_address_out     = '0;
      s_read_out        = 1'b0;
      s_write_out       = 1'b0;
      s_write_mask_out  = '0;
      s_write_value_out = '0;
      m_ready_out       = '0;
      m_fault_out       = '0;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter
// against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int N = 2;
  localparam int T = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [32*N-1:0] m_address_in = '0;
  logic [N-1:0]    m_read_in = '0;
  logic [N-1:0]    m_write_in = '0;
  logic [4*N-1:0]  m_write_mask_in = '0;
  logic [32*N-1:0] m_write_value_in = '0;
  logic [31:0]     m_read_value_out;
  logic [N-1:0]    m_ready_out;
  logic [N-1:0]    m_fault_out;
  logic [31:0]     s_address_out;
  logic            s_read_out;
  logic            s_write_out;
  logic [3:0]      s_write_mask_out;
  logic [31:0]     s_write_value_out;
  logic [31:0]     s_read_value_in = '0;
  logic            s_ready_in = 1'b0;
  logic            s_fault_in = 1'b0;

  bus_arbiter #(.N_PORTS(N), .TIMEOUT(T)) dut (
    .clk(clk),
    .reset(reset),
    .m_address_in(m_address_in),
    .m_read_in(m_read_in),
    .m_write_in(m_write_in),
    .m_write_mask_in(m_write_mask_in),
    .m_write_value_in(m_write_value_in),
    .m_read_value_out(m_read_value_out),
    .m_ready_out(m_ready_out),
    .m_fault_out(m_fault_out),
    .s_address_out(s_address_out),
    .s_read_out(s_read_out),
    .s_write_out(s_write_out),
    .s_write_mask_out(s_write_mask_out),
    .s_write_value_out(s_write_value_out),
    .s_read_value_in(s_read_value_in),
    .s_ready_in(s_ready_in),
    .s_fault_in(s_fault_in)
  );

  always #5 clk = ~clk;

  logic [31:0] a_addr [N];
  logic        a_rd   [N];
  logic        a_wr   [N];
  logic [3:0]  a_mask [N];
  logic [31:0] a_val  [N];
  logic        rst_req;
  logic        k_rdy;
  logic        k_flt;
  logic [31:0] k_rv;

  bit busy;
  int owner;
  int prev;
  int age;

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_flt;
    logic         e_rd;
    logic         e_wr;
    logic [31:0]  e_addr;
    logic [31:0]  e_val;
    logic [3:0]   e_mask;
    bit           fin;
    bit           hit;
    int           p;
    @(posedge clk);
    #1;
    reset = rst_req;
    for (int i = 0; i < N; i++) begin
      m_address_in[32*i +: 32]     = a_addr[i];
      m_read_in[i]                 = a_rd[i];
      m_write_in[i]                = a_wr[i];
      m_write_mask_in[4*i +: 4]    = a_mask[i];
      m_write_value_in[32*i +: 32] = a_val[i];
    end
    s_ready_in      = k_rdy;
    s_fault_in      = k_flt;
    s_read_value_in = k_rv;
    @(negedge clk);
    e_rdy = '0; e_flt = '0; e_rd = 0; e_wr = 0;
    e_addr = '0; e_val = '0; e_mask = '0;
    fin = 0; hit = 0;
    if (rst_req) begin
      busy = 0;
      prev = N - 1;
      age  = 0;
    end else if (!busy) begin
      for (int k = 1; k <= N; k++) begin
        p = (prev + k) % N;
        if (!hit && (a_rd[p] || a_wr[p])) begin
          hit = 1;
          owner = p;
        end
      end
      if (hit) begin
        busy = 1;
        age = 0;
      end
    end else begin
      e_addr = a_addr[owner];
      e_rd   = a_rd[owner];
      e_wr   = a_wr[owner];
      e_mask = a_mask[owner];
      e_val  = a_val[owner];
      if (k_flt) begin
        e_flt[owner] = 1;
        fin = 1;
      end else if (k_rdy) begin
        e_rdy[owner] = 1;
        fin = 1;
      end else if (!(a_rd[owner] || a_wr[owner])) begin
        fin = 1;
      end else if (age == T - 1) begin
        e_flt[owner] = 1;
        e_rd = 0;
        e_wr = 0;
        fin = 1;
      end else begin
        age++;
      end
      if (fin) begin
        prev = owner;
        busy = 0;
      end
    end
    check("s_addr", s_address_out, e_addr);
    check("s_read", s_read_out, e_rd);
    check("s_write", s_write_out, e_wr);
    check("s_mask", s_write_mask_out, e_mask);
    check("s_value", s_write_value_out, e_val);
    check("m_ready", m_ready_out, e_rdy);
    check("m_fault", m_fault_out, e_flt);
    check("m_rvalue", m_read_value_out, k_rv);
    for (int i = 0; i < N; i++)
      if (e_rdy[i] || e_flt[i]) begin
        a_rd[i] = 0;
        a_wr[i] = 0;
      end
  endtask

  initial begin
    int n;
    int exp_port;
    int grants;
    bit w;
    for (int i = 0; i < N; i++) begin
      a_addr[i] = '0; a_rd[i] = 0; a_wr[i] = 0;
      a_mask[i] = '0; a_val[i] = '0;
    end
    rst_req = 1; k_rdy = 0; k_flt = 0; k_rv = '0;
    busy = 0; owner = 0; prev = N - 1; age = 0;

    step();
    step();
    check("rst_ready", m_ready_out, 0);
    check("rst_sread", s_read_out, 0);
    rst_req = 0;

    a_rd[1] = 1; a_addr[1] = 32'h1000;
    k_rdy = 1; k_rv = 32'hDEADBEEF;
    step();
    check("rd_arb_sread", s_read_out, 0);
    step();
    check("rd_addr", s_address_out, 32'h1000);
    check("rd_ready", m_ready_out, 2'b10);
    check("rd_value", m_read_value_out, 32'hDEADBEEF);
    step();

    exp_port = 0; grants = 0;
    a_rd[0] = 1; a_rd[1] = 1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (m_ready_out != 0) begin
        check("fair_grant", m_ready_out[1], exp_port[0]);
        exp_port ^= 1;
        grants++;
      end
      a_rd[0] = 1; a_rd[1] = 1;
    end
    check("fair_count", grants, 4);
    a_rd[0] = 0; a_rd[1] = 0;
    step();

    k_rdy = 0;
    a_wr[0] = 1; a_addr[0] = 32'h2000;
    a_mask[0] = 4'b0101; a_val[0] = 32'h12345678;
    step();
    step();
    check("wr_addr", s_address_out, 32'h2000);
    check("wr_mask", s_write_mask_out, 4'b0101);
    check("wr_value", s_write_value_out, 32'h12345678);
    check("wr_write", s_write_out, 1);
    k_rdy = 1;
    step();
    check("wr_ready", m_ready_out, 2'b01);
    step();
    check("wr_once", m_ready_out, 0);

    k_rdy = 0;
    a_rd[0] = 1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (n == 0 || m_fault_out == 0) begin
        step();
        n++;
        if (m_fault_out != 0) break;
      end
    end
    check("to_cycles", n, 5);
    check("to_fault", m_fault_out, 2'b01);
    check("to_sread", s_read_out, 0);
    step();
    check("to_idle", s_read_out, 0);

    a_rd[1] = 1;
    step();
    k_flt = 1; k_rdy = 1;
    step();
    check("flt_fault", m_fault_out, 2'b10);
    check("flt_ready", m_ready_out, 0);
    k_flt = 0; k_rdy = 0;

    a_addr[0] = 32'h3000; a_rd[0] = 1;
    a_addr[1] = 32'h4000;
    step();
    step();
    rst_req = 1; k_rdy = 1;
    step();
    check("rst_nostrobe", m_ready_out | m_fault_out, 0);
    rst_req = 0; k_rdy = 0; a_rd[1] = 1;
    step();
    check("rst_drop", s_read_out, 0);
    step();
    check("rst_rearb", s_address_out, 32'h3000);
    a_rd[0] = 0;
    step();
    check("drop_nostrobe", m_ready_out | m_fault_out, 0);
    step();
    step();
    check("drop_rearb", s_address_out, 32'h4000);
    k_rdy = 1;
    step();

    for (int c = 0; c < 3000; c++) begin
      rst_req = ($urandom_range(99) == 0);
      k_rdy = ($urandom_range(9) < 4);
      k_flt = ($urandom_range(19) == 0);
      k_rv  = $urandom;
      for (int i = 0; i < N; i++) begin
        if (!(a_rd[i] || a_wr[i])) begin
          if ($urandom_range(2) == 0) begin
            w = 1'($urandom_range(1));
            a_rd[i]   = !w;
            a_wr[i]   = w;
            a_addr[i] = $urandom;
            a_mask[i] = 4'($urandom);
            a_val[i]  = $urandom;
          end
        end else if ($urandom_range(49) == 0) begin
          a_rd[i] = 0;
          a_wr[i] = 0;
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
